// File: rtl/trace_char_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the trace character arbiter.
package trace_char_arbiter_pkg;

    localparam logic [7:0] CARET = 8'h5E;
    localparam logic [7:0] HASH  = 8'h23;
    localparam logic [7:0] NUL   = 8'h00;

    localparam logic [1:0] FMT_NONE = 2'b00;
    localparam logic [1:0] FMT_REG  = 2'b01;
    localparam logic [1:0] FMT_MEM  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    // Owner index after id, wrapping at n producers.
    function automatic logic [1:0] next_id(input logic [1:0] id, input int n);
        return ((int'(id) + 1) >= n) ? 2'd0 : id + 2'd1;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/trace_char_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after i_ptr, wrapping.
module trace_char_arbiter_rr_pick #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [1:0]       i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [1:0]       o_idx,
    output logic             o_any
);

    // First pass scans ptr..N_REQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        o_grant = '0;
        o_idx   = 2'd0;
        o_any   = 1'b0;
        for (int n = 0; n < N_REQ; n++) begin
            if (!o_any && i_req[n] && (n >= int'(i_ptr))) begin
                o_any      = 1'b1;
                o_grant[n] = 1'b1;
                o_idx      = 2'(n);
            end
        end
        for (int n = 0; n < N_REQ; n++) begin
            if (!o_any && i_req[n] && (n < int'(i_ptr))) begin
                o_any      = 1'b1;
                o_grant[n] = 1'b1;
                o_idx      = 2'(n);
            end
        end
    end

endmodule

// File: rtl/trace_char_arbiter.sv
// Shares one trace format checker among N_REQ producers, one whole message at a time.
// Define RESULT_COUNT_EN to add per-producer reg/mem/bad verdict counters.
module trace_char_arbiter
    import trace_char_arbiter_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 63,
    parameter int MAX_LEN = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [8*N_REQ-1:0] i_req_char,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic [7:0]         o_out_char,
    output logic               o_out_valid,
    input  logic [1:0]         i_fmt_in,
    output logic [1:0]         o_grant_id,
    output logic               o_busy,
    output logic               o_res_valid,
    output logic [1:0]         o_res_id,
    output logic [1:0]         o_res_fmt,
    output logic               o_abort,
    output logic [1:0]         o_state
`ifdef RESULT_COUNT_EN
    ,
    output logic [16*N_REQ-1:0] o_reg_cnt,
    output logic [16*N_REQ-1:0] o_mem_cnt,
    output logic [16*N_REQ-1:0] o_bad_cnt
`endif
);

    localparam logic [6:0] IDLE_LIM = 7'(TIMEOUT - 1);
    localparam logic [6:0] LEN_LIM  = 7'(MAX_LEN);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_rr_ptr;
    logic [1:0] r_grant_id;
    logic [6:0] r_idle_cnt;
    logic [6:0] r_len_cnt;
    logic [7:0] r_out_char;
    logic       r_out_valid;

    logic       r_p1_v;
    logic [1:0] r_p1_id;
    logic       r_p2_v;
    logic [1:0] r_p2_id;
    logic       r_res_valid;
    logic [1:0] r_res_id;
    logic [1:0] r_res_fmt;

    logic [N_REQ-1:0] w_caret;
    logic [N_REQ-1:0] w_pick_grant;
    logic [1:0]       w_pick_idx;
    logic             w_pick_any;
    logic [N_REQ-1:0] w_own_sel;
    logic             w_own_valid;
    logic [7:0]       w_own_char;
    logic [N_REQ-1:0] w_ready;
    logic             w_fwd;
    logic [7:0]       w_fwd_char;
    logic             w_start;
    logic             w_end;
    logic             w_stall;

    always_comb begin
        w_caret     = '0;
        w_own_sel   = '0;
        w_own_valid = 1'b0;
        w_own_char  = NUL;
        for (int n = 0; n < N_REQ; n++) begin
            w_caret[n] = i_req_valid[n] && (i_req_char[8*n +: 8] == CARET);
            if (r_grant_id == 2'(n)) begin
                w_own_sel[n] = 1'b1;
                w_own_valid  = i_req_valid[n];
                w_own_char   = i_req_char[8*n +: 8];
            end
        end
    end

    trace_char_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .i_req   (w_caret),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Overlong is tested before acceptance so the offending character stays with its producer.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_fwd       = 1'b0;
        w_fwd_char  = NUL;
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                for (int n = 0; n < N_REQ; n++) begin
                    if (i_req_valid[n] && !w_caret[n]) begin
                        w_ready[n] = 1'b1;
                    end
                end
                if (w_pick_any) begin
                    w_ready     = w_ready | w_pick_grant;
                    w_fwd       = 1'b1;
                    w_fwd_char  = CARET;
                    w_start     = 1'b1;
                    w_state_nxt = ST_PASS;
                end
            end
            ST_PASS: begin
                if (w_own_valid && (r_len_cnt == LEN_LIM)) begin
                    w_state_nxt = ST_ABORT;
                end else if (w_own_valid) begin
                    w_ready    = w_own_sel;
                    w_fwd      = 1'b1;
                    w_fwd_char = w_own_char;
                    if (w_own_char == HASH) begin
                        w_end       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_idle_cnt == IDLE_LIM) begin
                    w_state_nxt = ST_ABORT;
                end else begin
                    w_stall = 1'b1;
                end
            end
            ST_ABORT: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= 2'd0;
            r_grant_id  <= 2'd0;
            r_idle_cnt  <= 7'd0;
            r_len_cnt   <= 7'd0;
            r_out_char  <= NUL;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_char  <= w_fwd_char;
            r_out_valid <= w_fwd;
            if (w_start) begin
                r_grant_id <= w_pick_idx;
                r_len_cnt  <= 7'd1;
                r_idle_cnt <= 7'd0;
            end else if (w_fwd) begin
                r_len_cnt  <= r_len_cnt + 7'd1;
                r_idle_cnt <= 7'd0;
            end else if (w_stall) begin
                r_idle_cnt <= r_idle_cnt + 7'd1;
            end
            if (w_end || (r_state == ST_ABORT)) begin
                r_rr_ptr <= next_id(r_grant_id, N_REQ);
            end
        end
    end

    // Owner id rides two stages while the checker digests '#'; fmt_in is sampled on the third edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_v      <= 1'b0;
            r_p1_id     <= 2'd0;
            r_p2_v      <= 1'b0;
            r_p2_id     <= 2'd0;
            r_res_valid <= 1'b0;
            r_res_id    <= 2'd0;
            r_res_fmt   <= FMT_NONE;
        end else begin
            r_p1_v      <= w_end;
            r_p1_id     <= r_grant_id;
            r_p2_v      <= r_p1_v;
            r_p2_id     <= r_p1_id;
            r_res_valid <= r_p2_v;
            if (r_p2_v) begin
                r_res_id  <= r_p2_id;
                r_res_fmt <= i_fmt_in;
            end
        end
    end

    assign o_req_ready = reset ? '0 : w_ready;
    assign o_out_char  = r_out_char;
    assign o_out_valid = r_out_valid;
    assign o_grant_id  = r_grant_id;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_res_valid = r_res_valid;
    assign o_res_id    = r_res_id;
    assign o_res_fmt   = r_res_fmt;
    assign o_abort     = (r_state == ST_ABORT);
    assign o_state     = r_state;

`ifdef RESULT_COUNT_EN
    logic [15:0] r_reg_cnt [N_REQ];
    logic [15:0] r_mem_cnt [N_REQ];
    logic [15:0] r_bad_cnt [N_REQ];

    // A verdict and an abort for the same producer cannot land in one cycle, so one bad increment suffices.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < N_REQ; n++) begin
                r_reg_cnt[n] <= 16'd0;
                r_mem_cnt[n] <= 16'd0;
                r_bad_cnt[n] <= 16'd0;
            end
        end else begin
            for (int n = 0; n < N_REQ; n++) begin
                if (r_res_valid && (r_res_id == 2'(n)) && (r_res_fmt == FMT_REG)) begin
                    r_reg_cnt[n] <= sat_inc(r_reg_cnt[n]);
                end
                if (r_res_valid && (r_res_id == 2'(n)) && (r_res_fmt == FMT_MEM)) begin
                    r_mem_cnt[n] <= sat_inc(r_mem_cnt[n]);
                end
                if ((r_res_valid && (r_res_id == 2'(n)) && (r_res_fmt == FMT_NONE)) ||
                    ((r_state == ST_ABORT) && (r_grant_id == 2'(n)))) begin
                    r_bad_cnt[n] <= sat_inc(r_bad_cnt[n]);
                end
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_out
        assign o_reg_cnt[16*g +: 16] = r_reg_cnt[g];
        assign o_mem_cnt[16*g +: 16] = r_mem_cnt[g];
        assign o_bad_cnt[16*g +: 16] = r_bad_cnt[g];
    end
`endif

endmodule

// File: tb/tb_trace_char_arbiter.sv
// Scoreboarded bench for trace_char_arbiter: character stream, verdict routing, aborts, resets.
module tb_trace_char_arbiter;
    import trace_char_arbiter_pkg::*;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_char;
    logic [N-1:0]   req_ready;
    logic [7:0]     out_char;
    logic           out_valid;
    logic [1:0]     fmt_in;
    logic [1:0]     grant_id;
    logic           busy;
    logic           res_valid;
    logic [1:0]     res_id;
    logic [1:0]     res_fmt;
    logic           abort;
    logic [1:0]     dut_state;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int abort_seen  = 0;
    int res_seen    = 0;
    int caret_cyc [4];
    int hash_cyc  [4];

    logic [7:0] exp_char_q [$];
    logic [3:0] exp_res_q  [$];

    trace_char_arbiter #(.N_REQ(N), .TIMEOUT(63), .MAX_LEN(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (req_valid),
        .i_req_char  (req_char),
        .o_req_ready (req_ready),
        .o_out_char  (out_char),
        .o_out_valid (out_valid),
        .i_fmt_in    (fmt_in),
        .o_grant_id  (grant_id),
        .o_busy      (busy),
        .o_res_valid (res_valid),
        .o_res_id    (res_id),
        .o_res_fmt   (res_fmt),
        .o_abort     (abort),
        .o_state     (dut_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Checker stand-in: verdict keyed on the first character after '^'.
    function automatic logic [1:0] code_of(input logic [7:0] c);
        if (c == "1") return FMT_REG;
        if (c == "2") return FMT_MEM;
        return FMT_NONE;
    endfunction

    int         ck_pos = 0;
    logic [1:0] ck_verdict = FMT_NONE;
    bit         ck_hash = 1'b0;

    always @(negedge clk) begin
        ck_hash = 1'b0;
        if (out_valid === 1'b1) begin
            if (out_char == CARET) begin
                ck_pos     = 1;
                ck_verdict = FMT_NONE;
            end else begin
                if (ck_pos == 1) ck_verdict = code_of(out_char);
                ck_pos++;
            end
            if (out_char == HASH) ck_hash = 1'b1;
        end
    end

    // Verdict is presented only in the cycle after '#' appears; 2'b11 elsewhere catches mis-timed sampling.
    always @(posedge clk) begin
        #1;
        fmt_in = ck_hash ? ck_verdict : 2'b11;
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (out_valid === 1'b1) begin
            if (exp_char_q.size() == 0) check("char_extra", 1, 0);
            else check("out_char", out_char, exp_char_q.pop_front());
        end else begin
            check("out_nul", {out_valid, out_char}, {1'b0, NUL});
        end
        if (res_valid === 1'b1) begin
            res_seen++;
            if (exp_res_q.size() == 0) begin
                check("res_extra", 1, 0);
            end else begin
                e = exp_res_q.pop_front();
                check("res_id", res_id, e[3:2]);
                check("res_fmt", res_fmt, e[1:0]);
                check("res_lat", cyc - hash_cyc[res_id], 3);
            end
        end
        if (abort === 1'b1) abort_seen++;
    end

    task automatic expect_msg(input int id, input string s, input bit with_res);
        int k = -1;
        for (int i = 0; i < s.len(); i++) if (k < 0 && s[i] == CARET) k = i;
        if (k >= 0) begin
            for (int i = k; i < s.len(); i++) exp_char_q.push_back(s[i]);
            if (with_res && s[s.len()-1] == HASH) exp_res_q.push_back({2'(id), code_of(s[k+1])});
        end
    endtask

    task automatic drive_char(input int id, input logic [7:0] c);
        bit taken = 1'b0;
        int n = 0;
        req_valid[id]      = 1'b1;
        req_char[8*id +: 8] = c;
        while (!taken && n < 400) begin
            @(negedge clk);
            taken = req_ready[id];
            if (taken && c == CARET) caret_cyc[id] = cyc;
            if (taken && c == HASH) hash_cyc[id] = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid[id] = 1'b0;
        check("accept", taken, 1);
    endtask

    task automatic send_msg(input int id, input string s);
        for (int i = 0; i < s.len(); i++) drive_char(id, s[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    string s_long;
    string s_full64;
    int    a0;
    int    r0;

    initial begin
        req_valid = '0;
        req_char  = '0;
        fmt_in    = 2'b11;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_valid[0]  = 1'b1;
        req_char[7:0] = CARET;
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_out", {out_valid, out_char}, 0);
        check("rst_busy", busy, 0);
        check("rst_gid", grant_id, 0);
        check("rst_res", res_valid, 0);
        check("rst_abort", abort, 0);
        check("rst_state", dut_state, ST_IDLE);
        req_valid = '0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Single message at full rate.
        expect_msg(0, "^10@00003000: $1 <= 0000000a#", 1);
        fork
            send_msg(0, "^10@00003000: $1 <= 0000000a#");
            begin
                repeat (3) @(negedge clk);
                check("mid_busy", busy, 1);
                check("mid_gid", grant_id, 0);
                check("mid_state", dut_state, ST_PASS);
            end
        join
        @(negedge clk);
        check("end_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;

        // Contention from pointer 0.
        do_reset();
        expect_msg(0, "^20@00001000: [00002000] <= 55#", 1);
        expect_msg(1, "^10@00001004: $5 <= 00000001#", 1);
        fork
            send_msg(0, "^20@00001000: [00002000] <= 55#");
            send_msg(1, "^10@00001004: $5 <= 00000001#");
            begin
                @(negedge clk);
                check("cont_ready0", req_ready, 2'b01);
                @(negedge clk);
                check("cont_ready1", req_ready, 2'b01);
            end
        join
        check("b2b_grant", caret_cyc[1] - hash_cyc[0], 1);
        repeat (5) @(posedge clk);
        #1;

        // Stall of 62 cycles is tolerated.
        a0 = abort_seen;
        expect_msg(1, "^5@00000000: x#", 1);
        send_msg(1, "^5@0000");
        repeat (62) @(posedge clk);
        #1;
        send_msg(1, "0000: x#");
        check("stall62_abort", abort_seen - a0, 0);
        repeat (5) @(posedge clk);
        #1;

        // Stall of 63 cycles aborts.
        expect_msg(1, "^5@0000", 0);
        r0 = res_seen;
        send_msg(1, "^5@0000");
        repeat (63) @(posedge clk);
        @(negedge clk);
        check("to_abort", abort, 1);
        check("to_state", dut_state, ST_ABORT);
        check("to_out", {out_valid, out_char}, 0);
        check("to_ready", req_ready, 0);
        @(negedge clk);
        check("to_pulse", abort, 0);
        check("to_idle", dut_state, ST_IDLE);
        @(posedge clk);
        #1;
        expect_msg(0, "^10@0000200c: $2 <= 00000003#", 1);
        expect_msg(1, "^20@00002010: [00003000] <= ff#", 1);
        fork
            send_msg(0, "^10@0000200c: $2 <= 00000003#");
            send_msg(1, "^20@00002010: [00003000] <= ff#");
        join
        repeat (5) @(posedge clk);
        #1;
        check("to_nores", res_seen - r0, 2);

        // Overlong: 65th character triggers abort and is not forwarded.
        s_long = "^";
        for (int i = 0; i < 63; i++) s_long = {s_long, "a"};
        expect_msg(0, s_long, 0);
        a0 = abort_seen;
        send_msg(0, s_long);
        req_valid[0]  = 1'b1;
        req_char[7:0] = "A";
        @(negedge clk);
        check("long_ready", req_ready[0], 0);
        check("long_noabort", abort, 0);
        @(negedge clk);
        check("long_abort", abort, 1);
        check("long_ready_ab", req_ready, 0);
        @(negedge clk);
        check("long_resync", req_ready[0], 1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        check("long_abort_cnt", abort_seen - a0, 1);
        expect_msg(1, "^11@00000010: $3 <= 00000004#", 1);
        expect_msg(0, "^21@00000020: [00000040] <= 01#", 1);
        fork
            send_msg(0, "^21@00000020: [00000040] <= 01#");
            send_msg(1, "^11@00000010: $3 <= 00000004#");
        join
        repeat (5) @(posedge clk);
        #1;

        // Exactly 64 characters including '#' completes.
        s_full64 = "^";
        for (int i = 0; i < 62; i++) s_full64 = {s_full64, "b"};
        s_full64 = {s_full64, "#"};
        a0 = abort_seen;
        expect_msg(1, s_full64, 1);
        send_msg(1, s_full64);
        repeat (5) @(posedge clk);
        #1;
        check("full64_noabort", abort_seen - a0, 0);

        // Reset the cycle after '#': message and pending verdict are dropped.
        r0 = res_seen;
        expect_msg(1, "^10@00000100: $7 <= 00000007#", 0);
        send_msg(1, "^10@00000100: $7 <= 00000007#");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mrst_out", {out_valid, out_char}, 0);
        check("mrst_busy", busy, 0);
        check("mrst_gid", grant_id, 0);
        check("mrst_res", res_valid, 0);
        check("mrst_abort", abort, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mrst_nores", res_seen - r0, 0);

        // Garbage ahead of '^' is consumed and dropped.
        expect_msg(0, "xyz^12#", 1);
        send_msg(0, "xyz^12#");
        repeat (8) @(posedge clk);
        #1;

        check("chars_left", exp_char_q.size(), 0);
        check("res_left", exp_res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trace_char_arbiter.md
Name: trace_char_arbiter

Overview:
- Shares one character-serial CPU trace format checker among N_REQ trace producers.
- Grants the checker input one whole message at a time (from '^' through '#'), round-robin, so messages from different producers never interleave.
- Aborts stalled or overlong messages.
- Routes the checker's 2-bit format verdict back to the producer that owned the message.

Parameters:
- N_REQ, 2, number of producers; legal range 2..4.
- TIMEOUT, 63, max consecutive cycles the owner may hold req_valid low mid-message before abort.
- MAX_LEN, 64, max characters per message including '^' and '#'.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  producer i has a character
- req_char  in  8*N_REQ  producer i character, bits [8i+7:8i]
- req_ready  out  N_REQ  character of producer i consumed this cycle
- out_char  out  8  registered character to checker; 8'h00 when idle
- out_valid  out  1  out_char carries a real forwarded character
- fmt_in  in  2  checker verdict: 00 none, 01 register write, 10 memory write
- grant_id  out  2  current owner, valid while busy
- busy  out  1  message in progress
- res_valid  out  1  one-cycle pulse: verdict available
- res_id  out  2  owner of the judged message
- res_fmt  out  2  verdict sampled for that message
- abort  out  1  one-cycle pulse: message aborted

Behaviour:
- Reset: state IDLE; rr pointer 0; out_char 8'h00; out_valid 0; busy 0; grant_id 0; res_valid, abort, req_ready all 0; result pipeline and counters cleared. A reset mid-message drops that message and any pending verdict, with no res_valid.
- FSM states: IDLE, PASS, ABORT.
- IDLE:
  - Candidates are producers with req_valid=1 and char=='^'.
  - Pick the first candidate at or after the rr pointer (wrapping). Assert its req_ready the same cycle; register '^' to out_char; set grant_id; go to PASS.
  - Any producer with req_valid=1 and a char other than '^' gets req_ready=1 and the char is discarded (resync), in IDLE only.
  - With no candidate: out_char=8'h00, out_valid=0.
- PASS:
  - req_ready[grant_id]=req_valid[grant_id]; all other ready=0.
  - Each accepted char appears on out_char the next cycle with out_valid=1.
  - A cycle with no accepted char drives out_char=8'h00, out_valid=0, and increments the idle counter. The idle counter clears on each accepted char.
  - Accepted '#': message ends, state IDLE next cycle, rr pointer = grant_id+1 mod N_REQ. A new '^' may be granted in the very next cycle (back-to-back).
  - A second '^' mid-message is forwarded unchanged; the checker resyncs on it.
- Abort triggers, evaluated in PASS:
  - The idle counter reaches TIMEOUT.
  - The length counter would exceed MAX_LEN without a '#'.
- ABORT:
  - Lasts one cycle: out_char=8'h00, out_valid=0, abort=1, req_ready=0.
  - Then IDLE with rr pointer advanced past the aborted owner. No res_valid for an aborted message.
- Verdict timing:
  - '#' accepted in cycle t; on out_char in t+1; checker state updates at the end of t+1; fmt_in valid in t+2.
  - The arbiter carries the owner id through a 2-stage pipeline, samples fmt_in at the end of t+2, and pulses res_valid with res_id and res_fmt in t+3.
  - Back-to-back messages keep separate pipeline slots; no loss.
- Widths: the idle counter and length counter are each 7 bits. grant_id is zero-extended when N_REQ<4.

Optional Feature:
- RESULT_COUNT_EN defined:
  - Adds outputs reg_cnt, mem_cnt, bad_cnt, each 16*N_REQ wide.
  - These are per-producer 16-bit saturating counters (hold at 16'hFFFF), incremented on res_valid when res_fmt is 01, 10, or 00 respectively.
  - Aborts increment bad_cnt of the owner.
  - All counters are cleared by reset.
- Undefined: the ports and counter logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package:
  - Character constants: CARET 8'h5E, HASH 8'h23, NUL 8'h00.
  - Format codes: FMT_NONE 00, FMT_REG 01, FMT_MEM 10.
  - FSM state encoding.
- One sub-module, rr_pick: combinational round-robin picker (request vector, pointer -> one-hot grant plus index).

Test Plan:
- Single message: producer 0 sends "^10@00003000: $1 <= 0000000a#" at full rate; checker returns 01 -> chars on out_char one cycle delayed; res_valid with res_id=0, res_fmt=01 exactly 3 cycles after '#' accepted.
- Contention: producers 0 and 1 assert '^' in the same cycle, pointer 0 -> 0 is granted and producer 1 is held with ready=0 until 0's '#'; then 1 is granted the next cycle; chars never interleave.
- Timeout: producer 1 stalls 63 cycles after "^5@0000" -> abort pulses once, out_char=8'h00, no res_valid, rr pointer moves on; the next producer is granted in IDLE.
- Overlong: 70 chars without '#' -> abort on the 65th char attempt; that char is not accepted.
- Reset mid-message and mid-pipeline: reset asserted the cycle after '#' -> no res_valid, all outputs at reset values.
- Garbage in IDLE: producer 0 sends "xyz^..." -> x, y, z are consumed and dropped; '^' is granted normally.
